// File: rtl/camera_tx.sv
// camera_tx: OV7670-style RGB565 test-pattern source for the camera parallel bus.
// Optional macro CAMERA_TX_SCROLL_EN adds a horizontal scroll that advances once per frame.
//
// state  | meaning
// S_IDLE | counters held at 0, bus driven low, waiting for en
// S_RUN  | scanning the frame; en re-checked only on the last byte of the last line
module camera_tx #(
   parameter int IMAGE_HEIGHT = 480,
   parameter int IMAGE_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 510,
   parameter int FRAME_WIDTH  = 784,
   parameter int V_OFFSET     = 20,
   parameter int VSYNC_LINES  = 3
) (
   input  logic        clk_2x,
   input  logic        n_rst,
   input  logic        en,
   input  logic [1:0]  in_pattern,
   input  logic [15:0] in_color,
   output logic        out_vsync,
   output logic        out_href,
   output logic [7:0]  out_data,
   output logic        out_frame_start,
   output logic [7:0]  out_frame_cnt,
   output logic        out_busy
);
   localparam int BW  = $clog2(2*FRAME_WIDTH + 1);
   localparam int LW  = $clog2(FRAME_HEIGHT + 1);
   localparam int XW  = 16;
   localparam int XW1 = XW + 1;
   localparam logic [BW-1:0] B_LAST = BW'(2*FRAME_WIDTH - 1);
   localparam logic [BW-1:0] B_ACT  = BW'(2*IMAGE_WIDTH);
   localparam logic [LW-1:0] L_LAST = LW'(FRAME_HEIGHT - 1);
   localparam logic [LW-1:0] L_VS   = LW'(VSYNC_LINES);
   localparam logic [LW-1:0] L_ACT0 = LW'(V_OFFSET);
   localparam logic [LW-1:0] L_ACT1 = LW'(V_OFFSET + IMAGE_HEIGHT);
   localparam logic [XW-1:0] BAR_W  = XW'(IMAGE_WIDTH / 8);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t        state_q, state_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic [LW-1:0] lcnt_q, lcnt_d;
   logic [1:0]    pat_q;
   logic [15:0]   color_q;
   logic          frame_go;
   logic          run;
   logic          vs_c, href_c, fs_c, y_b5;
   logic [XW-1:0] x_raw, x;
   logic [2:0]    bar_idx;
   logic [15:0]   pix;
   logic [7:0]    byte_c;

   assign run = (state_q == S_RUN);

   always_comb begin
      state_d  = state_q;
      bcnt_d   = bcnt_q;
      lcnt_d   = lcnt_q;
      frame_go = 1'b0;
      case (state_q)
         S_IDLE: begin
            bcnt_d = '0;
            lcnt_d = '0;
            if (en) begin
               state_d  = S_RUN;
               frame_go = 1'b1;
            end
         end
         S_RUN: begin
            if (bcnt_q == B_LAST) begin
               bcnt_d = '0;
               if (lcnt_q == L_LAST) begin
                  lcnt_d = '0;
                  if (en) frame_go = 1'b1;
                  else    state_d  = S_IDLE;
               end else begin
                  lcnt_d = lcnt_q + 1'b1;
               end
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_2x) begin
      if (!n_rst) begin
         state_q <= S_IDLE;
         bcnt_q  <= '0;
         lcnt_q  <= '0;
         pat_q   <= '0;
         color_q <= '0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         lcnt_q  <= lcnt_d;
         if (frame_go) begin
            pat_q   <= in_pattern;
            color_q <= in_color;
         end
      end
   end

   assign x_raw = XW'(bcnt_q >> 1);

`ifdef CAMERA_TX_SCROLL_EN
   logic [XW-1:0]  sofs_q;
   logic           started_q;
   logic [XW1-1:0] x_sum;

   // the very first frame after reset is unscrolled
   always_ff @(posedge clk_2x) begin
      if (!n_rst) begin
         sofs_q    <= '0;
         started_q <= 1'b0;
      end else if (frame_go) begin
         started_q <= 1'b1;
         if (started_q)
            sofs_q <= (sofs_q == XW'(IMAGE_WIDTH - 1)) ? '0 : sofs_q + 1'b1;
      end
   end

   assign x_sum = {1'b0, x_raw} + {1'b0, sofs_q};
   assign x     = (x_sum >= XW1'(IMAGE_WIDTH)) ? XW'(x_sum - XW1'(IMAGE_WIDTH)) : XW'(x_sum);
`else
   assign x = x_raw;
`endif

   assign vs_c   = run && (lcnt_q < L_VS);
   assign href_c = run && (lcnt_q >= L_ACT0) && (lcnt_q < L_ACT1) && (bcnt_q < B_ACT);
   assign fs_c   = run && (bcnt_q == '0) && (lcnt_q == '0);
   assign y_b5   = |((XW'(lcnt_q) - XW'(V_OFFSET)) & XW'(32));

   always_comb begin
      bar_idx = 3'd7;
      for (int i = 6; i >= 0; i--)
         if (x < BAR_W * XW'(i + 1)) bar_idx = 3'(i);
   end

   always_comb begin
      pix = 16'h0000;
      case (pat_q)
         2'd0: begin
            case (bar_idx)
               3'd0:    pix = 16'hFFFF;
               3'd1:    pix = 16'hFFE0;
               3'd2:    pix = 16'h07FF;
               3'd3:    pix = 16'h07E0;
               3'd4:    pix = 16'hF81F;
               3'd5:    pix = 16'hF800;
               3'd6:    pix = 16'h001F;
               default: pix = 16'h0000;
            endcase
         end
         2'd1:    pix = {x[7:3], x[7:2], x[7:3]};
         2'd2:    pix = (x[5] ^ y_b5) ? 16'hFFFF : 16'h0000;
         default: pix = color_q;
      endcase
   end

   // odd byte carries {R,G[5:3]}, even byte {G[2:0],B}
   assign byte_c = bcnt_q[0] ? pix[15:8] : pix[7:0];

   always_ff @(posedge clk_2x) begin
      if (!n_rst) begin
         out_vsync       <= 1'b0;
         out_href        <= 1'b0;
         out_data        <= 8'h00;
         out_frame_start <= 1'b0;
         out_frame_cnt   <= 8'h00;
         out_busy        <= 1'b0;
      end else begin
         out_vsync       <= vs_c;
         out_href        <= href_c;
         out_data        <= href_c ? byte_c : 8'h00;
         out_frame_start <= fs_c;
         if (fs_c) out_frame_cnt <= out_frame_cnt + 8'd1;
         out_busy        <= run;
      end
   end
endmodule
